// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : counter types and helpers for the UART receiver
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  typedef logic [15:0] cycle_cnt_t;
  typedef logic [3:0]  bit_cnt_t;

  localparam logic c_LINE_IDLE = 1'b1;

  // Terminal count for a counter that runs from 0 over n clocks.
  function automatic cycle_cnt_t cnt_last(input int unsigned n);
    return cycle_cnt_t'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_defs.vh
`default_nettype none
// ============================================================================
// uart_defs.vh : UART frame constants and baud divider, shared by rx and tx
// Revision     : 1.0 - initial release
// ============================================================================
`ifndef UART_DEFS_VH
`define UART_DEFS_VH

`define UART_DATA_BITS 8
`define UART_STOP_BITS 1

// Clocks per serial bit; callers keep the result within 4..65535.
`define UART_CYCLE(clk_frq, baud_rate) ((clk_frq) / (baud_rate))

`endif
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_sync : two-flop synchroniser for rx_in with falling-edge detect
// Revision     : 1.0 - initial release
// ============================================================================
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rx_in,
  output logic rxs,
  output logic start_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All stages reset to the idle level so release never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= c_LINE_IDLE;
      r_sync <= c_LINE_IDLE;
      r_prev <= c_LINE_IDLE;
    end else begin
      r_meta <= rx_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rxs        = r_sync;
  assign start_edge = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`include "uart_defs.vh"
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver with valid/ack output, framing and overrun flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FRQ   = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int         c_CYCLE      = `UART_CYCLE(CLK_FRQ, BAUD_RATE);
  localparam cycle_cnt_t c_CYCLE_LAST = cnt_last(c_CYCLE);
  localparam cycle_cnt_t c_HALF_LAST  = cnt_last(c_CYCLE / 2);
  localparam bit_cnt_t   c_LAST_BIT   = bit_cnt_t'(`UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t     r_state;
  cycle_cnt_t r_cycle_cnt;
  bit_cnt_t   r_bit_cnt;
  logic [7:0] r_shift;

  logic w_rxs;
  logic w_start_edge;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_in      (rx_in),
    .rxs        (w_rxs),
    .start_edge (w_start_edge)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;

      // A byte completing in the same cycle overrides this release below.
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_cycle_cnt <= '0;
            r_state     <= S_START;
          end
        end

        S_START: begin
          if (r_cycle_cnt == c_HALF_LAST) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_cycle_cnt <= '0;
              r_bit_cnt   <= '0;
              r_state     <= S_DATA;
            end
          end else begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (r_cycle_cnt == c_CYCLE_LAST) begin
            r_shift     <= {w_rxs, r_shift[7:1]};
            r_bit_cnt   <= r_bit_cnt + 4'd1;
            r_cycle_cnt <= '0;
            if (r_bit_cnt == c_LAST_BIT) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (r_cycle_cnt == c_CYCLE_LAST) begin
            r_cycle_cnt <= '0;
            if (w_rxs) begin
              if (!rx_valid || rx_ack) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              r_state      <= S_BREAK;
            end
          end else begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
          end
        end

        // A line held low after a bad stop bit must go high before rearming.
        S_BREAK: begin
          if (w_rxs) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
